vehicle_sensor_conditioner: RTL and testbench

- Upstream stage of the traffic-light controller; produces its `sensor` input from a raw farm-road inductive-loop signal.
- Synchronises the raw loop input, debounces it, and counts vehicle arrivals.
- Holds a sticky service request until the farm road has been served.
- Farm-green indication is fed back from the controller's farmway green bit.

---
 rtl/vehicle_sensor_conditioner.sv | 143 ++++++++++++++
 tb/tb_vehicle_sensor_conditioner.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_sensor_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vehicle_sensor_conditioner: loop sync/debounce, arrival count, sticky request.
// Optional macro STUCK_DETECT_EN adds the stuck-high loop fault detector.
// Rev 1.0
// ---------------------------------------------------------------------------
module vehicle_sensor_conditioner #(
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 3,
    parameter int STUCK_CYCLES = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loop_raw,
    input  logic             farm_green,
    output logic             sensor,
    output logic             loop_db,
    output logic [CNT_W-1:0] veh_count,
    output logic             stuck_fault
);
    typedef enum logic [1:0] {
        LOW    = 2'd0,
        QUAL_H = 2'd1,
        HIGH   = 2'd2,
        QUAL_L = 2'd3
    } state_t;

    localparam logic [7:0]       DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic       sync1;
    logic       loop_s;
    state_t     state;
    state_t     state_nxt;
    logic [7:0] dcnt;
    logic [7:0] dcnt_nxt;
    logic       db_q;
    logic       fg_q;
    logic       sensor_r;
    logic       arrival;
    logic       service;
    logic       green_fall;

    // ">=" lets DEB_CYCLES=1 leave a QUAL state after a single cycle.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        case (state)
            LOW: begin
                if (loop_s) begin
                    state_nxt = QUAL_H;
                    dcnt_nxt  = 8'd1;
                end
            end
            QUAL_H: begin
                if (!loop_s)               state_nxt = LOW;
                else if (dcnt >= DEB_LAST) state_nxt = HIGH;
                else                       dcnt_nxt  = dcnt + 8'd1;
            end
            HIGH: begin
                if (!loop_s) begin
                    state_nxt = QUAL_L;
                    dcnt_nxt  = 8'd1;
                end
            end
            QUAL_L: begin
                if (loop_s)                state_nxt = HIGH;
                else if (dcnt >= DEB_LAST) state_nxt = LOW;
                else                       dcnt_nxt  = dcnt + 8'd1;
            end
            default: state_nxt = LOW;
        endcase
    end

    assign loop_db    = (state == HIGH) || (state == QUAL_L);
    assign arrival    = loop_db && !db_q && !stuck_fault;
    assign service    = farm_green && !fg_q;
    assign green_fall = !farm_green && fg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            loop_s    <= 1'b0;
            state     <= LOW;
            dcnt      <= 8'd0;
            db_q      <= 1'b0;
            fg_q      <= 1'b0;
            veh_count <= '0;
            sensor_r  <= 1'b0;
        end else begin
            sync1  <= loop_raw;
            loop_s <= sync1;
            state  <= state_nxt;
            dcnt   <= dcnt_nxt;
            db_q   <= loop_db;
            fg_q   <= farm_green;

            if (service)
                veh_count <= '0;
            else if (arrival && (veh_count != CNT_MAX))
                veh_count <= veh_count + 1'b1;

            // Arrivals during farm green wait in veh_count until green ends.
            if (service)
                sensor_r <= 1'b0;
            else if (arrival && !farm_green)
                sensor_r <= 1'b1;
            else if (green_fall)
                sensor_r <= (veh_count != '0);
        end
    end

`ifdef STUCK_DETECT_EN
    localparam int SC_W = ($clog2(STUCK_CYCLES + 1) > 8) ? $clog2(STUCK_CYCLES + 1) : 8;
    localparam logic [SC_W-1:0] STUCK_LAST = SC_W'(STUCK_CYCLES - 1);

    logic [SC_W-1:0] stuck_cnt;
    logic            stuck_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt <= '0;
            stuck_r   <= 1'b0;
        end else begin
            if (!loop_db)
                stuck_cnt <= '0;
            else if (!stuck_r)
                stuck_cnt <= stuck_cnt + 1'b1;
            if (loop_db && (stuck_cnt == STUCK_LAST))
                stuck_r <= 1'b1;
        end
    end

    assign stuck_fault = stuck_r;
`else
    assign stuck_fault = 1'b0;
`endif

    // A stuck loop still requests service so the farm road is not starved.
    assign sensor = sensor_r || stuck_fault;

endmodule
`default_nettype wire

// File: tb/tb_vehicle_sensor_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vehicle_sensor_conditioner: scoreboard bench for the loop conditioner.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vehicle_sensor_conditioner;
    localparam int CNT_W = 3;
`ifdef STUCK_DETECT_EN
    localparam int STUCK_CYC = 20;
    localparam bit STUCK_ON  = 1'b1;
`else
    localparam int STUCK_CYC = 200;
    localparam bit STUCK_ON  = 1'b0;
`endif

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             loop_raw   = 1'b0;
    logic             farm_green = 1'b0;
    logic             sensor;
    logic             loop_db;
    logic [CNT_W-1:0] veh_count;
    logic             stuck_fault;

    typedef struct {
        string      tag;
        logic [5:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vehicle_sensor_conditioner #(
        .DEB_CYCLES  (4),
        .CNT_W       (CNT_W),
        .STUCK_CYCLES(STUCK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .loop_raw   (loop_raw),
        .farm_green (farm_green),
        .sensor     (sensor),
        .loop_db    (loop_db),
        .veh_count  (veh_count),
        .stuck_fault(stuck_fault)
    );

    // Observation word: {stuck_fault, sensor, loop_db, veh_count}
    function automatic logic [5:0] obs();
        return {stuck_fault, sensor, loop_db, veh_count};
    endfunction

    function automatic logic [5:0] pack(input bit st, input bit se, input bit db, input logic [2:0] cnt);
        return {st, se, db, cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        loop_raw   = 1'b0;
        farm_green = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic vehicle();
        loop_raw = 1'b1;
        repeat (6) tick();
        loop_raw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n      = 1'b0;
        loop_raw   = 1'b1;
        farm_green = 1'b1;
        sb.push_back('{"reset_hold", pack(1'b0, 1'b0, 1'b0, 3'd0)});
        repeat (3) tick();
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
        end
    endtask

    task automatic test_latency();
        exp_t e;
        do_reset();
        loop_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            sb.push_back('{$sformatf("latency_c%0d", i),
                           pack(1'b0, i >= 7, i >= 6, (i >= 7) ? 3'd1 : 3'd0)});
            tick();
            e = sb.pop_front();
            checks++;
            if (obs() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            loop_raw = (i < 8) ? ((i % 2) == 0) : 1'b0;
            sb.push_back('{$sformatf("bounce_c%0d", i), pack(1'b0, 1'b0, 1'b0, 3'd0)});
            tick();
            e = sb.pop_front();
            checks++;
            if (obs() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
            end
        end
    endtask

    task automatic test_count_serve();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            vehicle();
            sb.push_back('{$sformatf("count_v%0d", k), pack(1'b0, 1'b1, 1'b0, 3'(k))});
            e = sb.pop_front();
            checks++;
            if (obs() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
            end
        end
        farm_green = 1'b1;
        sb.push_back('{"serve_rise", pack(1'b0, 1'b0, 1'b0, 3'd0)});
        tick();
        farm_green = 1'b0;
        sb.push_back('{"serve_fall_empty", pack(1'b0, 1'b0, 1'b0, 3'd0)});
        for (int j = 0; j < 2; j++) begin
            e = sb.pop_front();
            checks++;
            if (obs() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
            end
            if (j == 0) tick();
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            vehicle();
            sb.push_back('{$sformatf("sat_v%0d", k),
                           pack(1'b0, 1'b1, 1'b0, (k > 7) ? 3'd7 : 3'(k))});
            e = sb.pop_front();
            checks++;
            if (obs() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
            end
        end
        loop_raw = 1'b1;
        repeat (6) tick();
        sb.push_back('{"coincide_pre", pack(1'b0, 1'b1, 1'b1, 3'd7)});
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
        end
        farm_green = 1'b1;
        sb.push_back('{"coincide_serve", pack(1'b0, 1'b0, 1'b1, 3'd0)});
        tick();
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
        end
        loop_raw = 1'b0;
        repeat (6) tick();
        farm_green = 1'b0;
        sb.push_back('{"coincide_fall", pack(1'b0, 1'b0, 1'b0, 3'd0)});
        tick();
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
        end
    endtask

    task automatic test_green_arrival();
        exp_t e;
        do_reset();
        farm_green = 1'b1;
        tick();
        vehicle();
        sb.push_back('{"green_arrival", pack(1'b0, 1'b0, 1'b0, 3'd1)});
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
        end
        farm_green = 1'b0;
        sb.push_back('{"green_fall_req", pack(1'b0, 1'b1, 1'b0, 3'd1)});
        tick();
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
        end
    endtask

    task automatic test_stuck();
        exp_t e;
        bit   st;
        bit   live;
        do_reset();
        loop_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 31) farm_green = 1'b1;
            st   = STUCK_ON && (i >= 26);
            live = (i >= 7) && (i < 31);
            sb.push_back('{$sformatf("stuck_c%0d", i),
                           pack(st, live || st, i >= 6, live ? 3'd1 : 3'd0)});
            tick();
            e = sb.pop_front();
            checks++;
            if (obs() !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
            end
        end
        #2;
        rst_n = 1'b0;
        sb.push_back('{"midop_reset", pack(1'b0, 1'b0, 1'b0, 3'd0)});
        #1;
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.tag, obs(), e.val);
        end
        tick();
        loop_raw   = 1'b0;
        farm_green = 1'b0;
        rst_n      = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_count_serve();
        test_saturate();
        test_green_arrival();
        test_stuck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
